// File: rtl/bcd_count_core_if.sv
// rtl/bcd_count_core_if.sv - strobe, trigger and display bundle for bcd_count_core; `down` exists only with DOWN_COUNT_EN
interface bcd_count_core_if #(
  parameter int DIGITS = 6
);
  logic                  inc_clk;
  logic                  ref_clk;
  logic [DIGITS-1:0]     trigger;
`ifdef DOWN_COUNT_EN
  logic                  down;
`endif
  logic [4*DIGITS-1:0]   display_bcd;
  logic                  busy;
  logic                  overflow;

`ifdef DOWN_COUNT_EN
  modport master (output inc_clk, ref_clk, trigger, down, input display_bcd, busy, overflow);
  modport slave  (input inc_clk, ref_clk, trigger, down, output display_bcd, busy, overflow);
`else
  modport master (output inc_clk, ref_clk, trigger, input display_bcd, busy, overflow);
  modport slave  (input inc_clk, ref_clk, trigger, output display_bcd, busy, overflow);
`endif
endinterface

// File: rtl/bcd_count_core.sv
// rtl/bcd_count_core.sv - multi-digit BCD counter with one-digit-per-clock carry ripple and deferred display refresh
// Optional decrement support is enabled by defining DOWN_COUNT_EN.
module bcd_count_core #(
  parameter int DIGITS = 6
) (
  input logic             clk,
  input logic             rst_n,
  bcd_count_core_if.slave bus
);
  localparam int W     = 4 * DIGITS;
  localparam int PTR_W = 3;
  localparam logic [PTR_W-1:0] TOP_PTR = PTR_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CARRY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       disp_q, disp_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               ovf_q, ovf_d;
  logic               pend_q, pend_d;
`ifdef DOWN_COUNT_EN
  logic               down_q, down_d;
`endif

  logic [PTR_W-1:0]   low_ptr;
  logic [PTR_W+1:0]   base;
  logic [3:0]         digit;
  logic [3:0]         digit_nxt;
  logic               wrap;

  // Lowest set trigger bit selects the decade; an all-zero trigger means units.
  always_comb begin
    low_ptr = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bus.trigger[i]) low_ptr = PTR_W'(i);
    end
  end

  always_comb begin
    base  = {ptr_q, 2'b00};
    digit = work_q[base +: 4];
`ifdef DOWN_COUNT_EN
    if (down_q) begin
      wrap      = (digit == 4'd0);
      digit_nxt = wrap ? 4'd9 : digit - 4'd1;
    end else begin
      wrap      = (digit == 4'd9);
      digit_nxt = wrap ? 4'd0 : digit + 4'd1;
    end
`else
    wrap      = (digit == 4'd9);
    digit_nxt = wrap ? 4'd0 : digit + 4'd1;
`endif
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    disp_d  = disp_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
`ifdef DOWN_COUNT_EN
    down_d  = down_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          disp_d = work_q;
          pend_d = 1'b0;
        end
        if (bus.inc_clk) begin
          ptr_d   = low_ptr;
          state_d = STEP;
`ifdef DOWN_COUNT_EN
          down_d  = bus.down;
`endif
        end
        // A refresh coinciding with an increment waits so it shows the new value.
        if (bus.ref_clk) begin
          if (bus.inc_clk) pend_d = 1'b1;
          else             disp_d = work_q;
        end
      end
      STEP, CARRY: begin
        work_d[base +: 4] = digit_nxt;
        if (bus.ref_clk) pend_d = 1'b1;
        if (wrap && ptr_q != TOP_PTR) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = CARRY;
        end else begin
          if (wrap) ovf_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      disp_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
`ifdef DOWN_COUNT_EN
      down_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
`ifdef DOWN_COUNT_EN
      down_q  <= down_d;
`endif
    end
  end

  assign bus.display_bcd = disp_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_bcd_count_core.sv
// tb/tb_bcd_count_core.sv - randomized self-checking bench for bcd_count_core against a decimal-arithmetic model
module tb_bcd_count_core;
  localparam int DIGITS = 6;
  localparam int W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_count_core_if #(.DIGITS(DIGITS)) bus ();
  bcd_count_core #(.DIGITS(DIGITS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_checks  = 0;
  int n_fail    = 0;
  int model_val = 0;
  bit model_ovf = 1'b0;
  bit down_r    = 1'b0;

  function automatic int pow10(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int lowest(logic [DIGITS-1:0] t);
    int k = 0;
    for (int i = DIGITS - 1; i >= 0; i--) if (t[i]) k = i;
    return k;
  endfunction

  // Number of clock edges the increment occupies: one per digit the carry touches.
  function automatic int ripple_len(int val, int k, bit dn);
    int n   = 1;
    int idx = k;
    while (idx < DIGITS - 1 && ((val / pow10(idx)) % 10) == (dn ? 0 : 9)) begin
      n++;
      idx++;
    end
    return n;
  endfunction

  task automatic idle_inputs();
    bus.inc_clk = 1'b0;
    bus.ref_clk = 1'b0;
    bus.trigger = '0;
`ifdef DOWN_COUNT_EN
    bus.down    = down_r;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_val = 0;
    model_ovf = 1'b0;
  endtask

  task automatic pulse_inc(input logic [DIGITS-1:0] t, input bit with_ref, output int cyc, output int exp_cyc);
    int k;
    @(posedge clk);
    #1;
    bus.inc_clk = 1'b1;
    bus.ref_clk = with_ref;
    bus.trigger = t;
`ifdef DOWN_COUNT_EN
    bus.down    = down_r;
`endif
    @(posedge clk);
    #1;
    bus.inc_clk = 1'b0;
    bus.ref_clk = 1'b0;
    bus.trigger = DIGITS'($urandom);
    k       = lowest(t);
    exp_cyc = ripple_len(model_val, k, down_r);
    if (down_r) begin
      model_val = model_val - pow10(k);
      if (model_val < 0) begin model_val += pow10(DIGITS); model_ovf = 1'b1; end
    end else begin
      model_val = model_val + pow10(k);
      if (model_val >= pow10(DIGITS)) begin model_val -= pow10(DIGITS); model_ovf = 1'b1; end
    end
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 32) begin
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic refresh();
    @(posedge clk);
    #1 bus.ref_clk = 1'b1;
    @(posedge clk);
    #1 bus.ref_clk = 1'b0;
  endtask

  task automatic build(int v);
    int c, e;
    logic [DIGITS-1:0] t;
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = 0; j < (v / pow10(i)) % 10; j++) begin
        t = (DIGITS'($urandom) << (i + 1)) | (DIGITS'(1) << i);
        pulse_inc(t, 1'b0, c, e);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.display_bcd !== '0) begin n_fail++; $display("FAIL reset_display: got %h want 0", bus.display_bcd); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    rst_n = 1'b1;
    model_val = 0;
    model_ovf = 1'b0;
  endtask

  task automatic test_single_inc();
    int c, e;
    pulse_inc(DIGITS'(1), 1'b0, c, e);
    n_checks++; if (c != 1) begin n_fail++; $display("FAIL single_busy: got %0d cycles want 1", c); end
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(1)) begin n_fail++; $display("FAIL single_display: got %h want %h", bus.display_bcd, to_bcd(1)); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b want 0", bus.overflow); end
  endtask

  task automatic test_carry();
    int c, e;
    for (int i = 0; i < 8; i++) pulse_inc('0, 1'b0, c, e);
    pulse_inc('0, 1'b0, c, e);
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL carry_busy: got %0d cycles want 2", c); end
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(10)) begin n_fail++; $display("FAIL carry_display: got %h want %h", bus.display_bcd, to_bcd(10)); end
  endtask

  task automatic test_decade_select();
    int c, e;
    do_reset();
    build(950);
    pulse_inc(DIGITS'(6'b000100), 1'b0, c, e);
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL decade_busy: got %0d cycles want 2", c); end
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(1050)) begin n_fail++; $display("FAIL decade_display: got %h want %h", bus.display_bcd, to_bcd(1050)); end
  endtask

  task automatic test_overflow();
    int c, e;
    do_reset();
    build(999999);
    pulse_inc(DIGITS'(1), 1'b0, c, e);
    n_checks++; if (c != DIGITS) begin n_fail++; $display("FAIL ovf_busy: got %0d cycles want %0d", c, DIGITS); end
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(0)) begin n_fail++; $display("FAIL ovf_display: got %h want 0", bus.display_bcd); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
    pulse_inc(DIGITS'(1), 1'b0, c, e);
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(1)) begin n_fail++; $display("FAIL ovf_next_display: got %h want %h", bus.display_bcd, to_bcd(1)); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_deferred_ref();
    int c, e;
    do_reset();
    build(99);
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(99)) begin n_fail++; $display("FAIL defer_pre: got %h want %h", bus.display_bcd, to_bcd(99)); end
    @(posedge clk);
    #1 bus.inc_clk = 1'b1; bus.trigger = DIGITS'(1);
    @(posedge clk);
    #1 bus.inc_clk = 1'b0; bus.ref_clk = 1'b1;
    @(posedge clk);
    #1 bus.ref_clk = 1'b0;
    model_val = 100;
    c = 0;
    while (bus.busy === 1'b1 && c < 32) begin
      n_checks++; if (bus.display_bcd !== to_bcd(99)) begin n_fail++; $display("FAIL defer_hold: got %h want %h", bus.display_bcd, to_bcd(99)); end
      c++;
      @(posedge clk);
      #1;
    end
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL defer_busy_tail: got %0d cycles want 2", c); end
    n_checks++; if (bus.display_bcd !== to_bcd(99)) begin n_fail++; $display("FAIL defer_at_fall: got %h want %h", bus.display_bcd, to_bcd(99)); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.display_bcd !== to_bcd(100)) begin n_fail++; $display("FAIL defer_new: got %h want %h", bus.display_bcd, to_bcd(100)); end
    pulse_inc(DIGITS'(1), 1'b1, c, e);
    @(posedge clk);
    #1;
    n_checks++; if (bus.display_bcd !== to_bcd(101)) begin n_fail++; $display("FAIL same_cycle_ref: got %h want %h", bus.display_bcd, to_bcd(101)); end
  endtask

  task automatic test_reset_mid_ripple();
    int c, e;
    do_reset();
    build(9999);
    refresh();
    @(posedge clk);
    #1 bus.inc_clk = 1'b1; bus.trigger = DIGITS'(1);
    @(posedge clk);
    #1 bus.inc_clk = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.display_bcd !== '0) begin n_fail++; $display("FAIL mid_rst_display: got %h want 0", bus.display_bcd); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overflow: got %b want 0", bus.overflow); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_val = 0;
    model_ovf = 1'b0;
    pulse_inc(DIGITS'(1), 1'b0, c, e);
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(1)) begin n_fail++; $display("FAIL mid_after: got %h want %h", bus.display_bcd, to_bcd(1)); end
  endtask

  task automatic test_random();
    int c, e;
    bit with_ref;
    logic [DIGITS-1:0] t;
    do_reset();
    build(int'($urandom_range(0, 999999)));
    for (int n = 0; n < 40; n++) begin
      t = ($urandom_range(0, 1) == 1) ? DIGITS'($urandom) : (DIGITS'(1) << $urandom_range(0, DIGITS - 1));
      with_ref = 1'($urandom_range(0, 1));
      pulse_inc(t, with_ref, c, e);
      n_checks++; if (c != e) begin n_fail++; $display("FAIL rand_busy: got %0d cycles want %0d", c, e); end
      if (with_ref) begin
        @(posedge clk);
        #1;
      end else begin
        refresh();
      end
      n_checks++; if (bus.display_bcd !== to_bcd(model_val)) begin n_fail++; $display("FAIL rand_display: got %h want %h", bus.display_bcd, to_bcd(model_val)); end
      n_checks++; if (bus.overflow !== model_ovf) begin n_fail++; $display("FAIL rand_overflow: got %b want %b", bus.overflow, model_ovf); end
    end
  endtask

`ifdef DOWN_COUNT_EN
  task automatic test_down();
    int c, e;
    down_r = 1'b0;
    do_reset();
    build(100);
    down_r = 1'b1;
    idle_inputs();
    pulse_inc(DIGITS'(1), 1'b0, c, e);
    n_checks++; if (c != 3) begin n_fail++; $display("FAIL down_busy: got %0d cycles want 3", c); end
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(99)) begin n_fail++; $display("FAIL down_display: got %h want %h", bus.display_bcd, to_bcd(99)); end
    do_reset();
    pulse_inc(DIGITS'(1), 1'b0, c, e);
    refresh();
    n_checks++; if (bus.display_bcd !== to_bcd(999999)) begin n_fail++; $display("FAIL down_wrap: got %h want %h", bus.display_bcd, to_bcd(999999)); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL down_overflow: got %b want 1", bus.overflow); end
    test_random();
    down_r = 1'b0;
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single_inc();
    test_carry();
    test_decade_select();
    test_overflow();
    test_deferred_ref();
    test_reset_mid_ripple();
    test_random();
`ifdef DOWN_COUNT_EN
    test_down();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
